// File: rtl/epl_fi_engine.sv
`default_nettype none
// ============================================================================
// Module   : epl_fi_engine
// Purpose  : Runtime-programmable fault-injection engine for the ECC-protected
//            FFRAM datapath. NUM_SLOTS independent slots, each with an address
//            match, a codeword mask and a mode. Write faults are applied
//            combinationally. Read faults are decided when the read is issued,
//            then delivered RD_LAT cycles later when the codeword returns.
//            A saturating counter tracks the accesses that were disturbed.
// Ports    : pCLOCK_i / nRESET_i      clock, synchronous active-low reset
//            pFiEn_i                  global injection enable
//            pCfg*_i                  slot configuration write port
//            pWrite_i/pWrA_i/pWrCw_i  write access in, pWrCw_o injected out
//            pRead_i/pRdA_i           read issue
//            pRdValid_i/pRdCw_i       read data return, pRdCw_o injected out
//            pCntClr_i                clear injection counter
//            pSlotArmed_o             per-slot armed flags
//            pInjCnt_o                saturating injection count
// Revision : 1.0  initial release
// ============================================================================
module epl_fi_engine #(
  parameter int ADDR_WIDTH = 8,
  parameter int CW_WIDTH   = 39,
  parameter int NUM_SLOTS  = 4,
  parameter int RD_LAT     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          pCLOCK_i,
  input  logic                          nRESET_i,
  input  logic                          pFiEn_i,
  input  logic                          pCfgWe_i,
  input  logic [$clog2(NUM_SLOTS)-1:0]  pCfgSlot_i,
  input  logic [ADDR_WIDTH-1:0]         pCfgAddr_i,
  input  logic [CW_WIDTH-1:0]           pCfgMask_i,
  input  logic [2:0]                    pCfgMode_i,
  input  logic                          pWrite_i,
  input  logic [ADDR_WIDTH-1:0]         pWrA_i,
  input  logic [CW_WIDTH-1:0]           pWrCw_i,
  output logic [CW_WIDTH-1:0]           pWrCw_o,
  input  logic                          pRead_i,
  input  logic [ADDR_WIDTH-1:0]         pRdA_i,
  input  logic                          pRdValid_i,
  input  logic [CW_WIDTH-1:0]           pRdCw_i,
  output logic [CW_WIDTH-1:0]           pRdCw_o,
  input  logic                          pCntClr_i,
  output logic [NUM_SLOTS-1:0]          pSlotArmed_o,
  output logic [CNT_WIDTH-1:0]          pInjCnt_o
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  localparam logic [2:0] c_MODE_OFF     = 3'b000;
  localparam logic [2:0] c_MODE_WR_FLIP = 3'b001;
  localparam logic [2:0] c_MODE_WR_ZERO = 3'b010;
  localparam logic [2:0] c_MODE_WR_ONE  = 3'b011;
  localparam logic [2:0] c_MODE_RD_FLIP = 3'b100;
  localparam logic [2:0] c_MODE_RD_ONCE = 3'b101;

  // Slot storage
  logic [ADDR_WIDTH-1:0] r_slotAddr [NUM_SLOTS];
  logic [CW_WIDTH-1:0]   r_slotMask [NUM_SLOTS];
  logic [2:0]            r_slotMode [NUM_SLOTS];

  // Per-slot contributions, OR-reduced below
  logic [CW_WIDTH-1:0]   w_zSlot [NUM_SLOTS];
  logic [CW_WIDTH-1:0]   w_oSlot [NUM_SLOTS];
  logic [CW_WIDTH-1:0]   w_fSlot [NUM_SLOTS];
  logic [CW_WIDTH-1:0]   w_rSlot [NUM_SLOTS];

  logic [CW_WIDTH-1:0]   w_z;
  logic [CW_WIDTH-1:0]   w_o;
  logic [CW_WIDTH-1:0]   w_f;
  logic [CW_WIDTH-1:0]   w_r;
  logic                  w_wrInj;
  logic                  w_rdApply;

  // Read tag pipeline: stage 0 is written at issue, stage RD_LAT-1 is
  // presented to the returning codeword.
  logic                  r_tagVld  [RD_LAT];
  logic [CW_WIDTH-1:0]   r_tagMask [RD_LAT];

  logic [CNT_WIDTH-1:0]  r_injCnt;
  logic [1:0]            w_incr;
  logic [CNT_WIDTH:0]    w_cntSum;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic w_wrHit;
    logic w_rdHit;
    logic w_rdType;

    assign w_wrHit  = pFiEn_i & pWrite_i & (r_slotAddr[gi] == pWrA_i);
    assign w_rdType = (r_slotMode[gi] == c_MODE_RD_FLIP) |
                      (r_slotMode[gi] == c_MODE_RD_ONCE);
    assign w_rdHit  = pFiEn_i & pRead_i & w_rdType & (r_slotAddr[gi] == pRdA_i);

    assign w_zSlot[gi] = (w_wrHit && r_slotMode[gi] == c_MODE_WR_ZERO) ? r_slotMask[gi] : '0;
    assign w_oSlot[gi] = (w_wrHit && r_slotMode[gi] == c_MODE_WR_ONE)  ? r_slotMask[gi] : '0;
    assign w_fSlot[gi] = (w_wrHit && r_slotMode[gi] == c_MODE_WR_FLIP) ? r_slotMask[gi] : '0;
    assign w_rSlot[gi] = w_rdHit ? r_slotMask[gi] : '0;

    // Armed = any defined non-OFF mode; 11x codes are reserved.
    assign pSlotArmed_o[gi] = (r_slotMode[gi] != c_MODE_OFF) &&
                              (r_slotMode[gi][2:1] != 2'b11);

    // Configuration write wins over one-shot consumption in the same cycle.
    always_ff @(posedge pCLOCK_i) begin
      if (!nRESET_i) begin
        r_slotAddr[gi] <= '0;
        r_slotMask[gi] <= '0;
        r_slotMode[gi] <= c_MODE_OFF;
      end else if (pCfgWe_i && pCfgSlot_i == SLOT_W'(gi)) begin
        r_slotAddr[gi] <= pCfgAddr_i;
        r_slotMask[gi] <= pCfgMask_i;
        r_slotMode[gi] <= pCfgMode_i;
      end else if (w_rdHit && r_slotMode[gi] == c_MODE_RD_ONCE) begin
        r_slotMode[gi] <= c_MODE_OFF;
      end
    end
  end

  always_comb begin
    w_z = '0;
    w_o = '0;
    w_f = '0;
    w_r = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_z = w_z | w_zSlot[i];
      w_o = w_o | w_oSlot[i];
      w_f = w_f | w_fSlot[i];
      w_r = w_r | w_rSlot[i];
    end
  end

  assign pWrCw_o   = ((pWrCw_i & ~w_z) | w_o) ^ w_f;
  assign w_wrInj   = |(w_z | w_o | w_f);

  // A tag arriving without a returning codeword is dropped silently.
  assign w_rdApply = r_tagVld[RD_LAT-1] & pRdValid_i;
  assign pRdCw_o   = w_rdApply ? (pRdCw_i ^ r_tagMask[RD_LAT-1]) : pRdCw_i;

  // The mask is captured with the tag so later slot reconfiguration cannot
  // alter a read that is already in flight.
  always_ff @(posedge pCLOCK_i) begin
    if (!nRESET_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tagVld[i]  <= 1'b0;
        r_tagMask[i] <= '0;
      end
    end else begin
      r_tagVld[0]  <= |w_r;
      r_tagMask[0] <= w_r;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tagVld[i]  <= r_tagVld[i-1];
        r_tagMask[i] <= r_tagMask[i-1];
      end
    end
  end

  // Up to one write and one read injection per cycle; the extra MSB of the
  // sum detects overflow for saturation.
  assign w_incr   = {1'b0, w_wrInj} + {1'b0, w_rdApply};
  assign w_cntSum = {1'b0, r_injCnt} + (CNT_WIDTH+1)'(w_incr);

  always_ff @(posedge pCLOCK_i) begin
    if (!nRESET_i) begin
      r_injCnt <= '0;
    end else if (pCntClr_i) begin
      r_injCnt <= '0;
    end else if (w_cntSum[CNT_WIDTH]) begin
      r_injCnt <= '1;
    end else begin
      r_injCnt <= w_cntSum[CNT_WIDTH-1:0];
    end
  end

  assign pInjCnt_o = r_injCnt;

endmodule
`default_nettype wire

// File: tb/tb_epl_fi_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_epl_fi_engine
// Purpose  : Self-checking bench for epl_fi_engine. A behavioural model
//            (slot arrays plus a queue of pending read disturbs keyed by
//            delivery cycle) predicts every output each cycle. A second
//            instance with a 2-bit counter shares the stimulus to exercise
//            saturation. Directed scenarios add literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_epl_fi_engine;
  localparam int AW = 8;
  localparam int CW = 39;
  localparam int NS = 4;
  localparam int RL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nRst = 1'b0, fiEn = 1'b1, cfgWe = 1'b0;
  logic [1:0]    cfgSlot = '0;
  logic [AW-1:0] cfgAddr = '0, wrA = '0, rdA = '0;
  logic [CW-1:0] cfgMask = '0, wrCw = '0, rdCw = '0;
  logic [2:0]    cfgMode = '0;
  logic          wr = 1'b0, rd = 1'b0, rdValid = 1'b0, cntClr = 1'b0;

  logic [CW-1:0] wrCwO, rdCwO, wrCwO2, rdCwO2;
  logic [NS-1:0] armed, armed2;
  logic [15:0]   cnt;
  logic [1:0]    cnt2;

  epl_fi_engine #(.ADDR_WIDTH(AW), .CW_WIDTH(CW), .NUM_SLOTS(NS), .RD_LAT(RL), .CNT_WIDTH(16)) dut (
    .pCLOCK_i(clk), .nRESET_i(nRst), .pFiEn_i(fiEn), .pCfgWe_i(cfgWe), .pCfgSlot_i(cfgSlot),
    .pCfgAddr_i(cfgAddr), .pCfgMask_i(cfgMask), .pCfgMode_i(cfgMode), .pWrite_i(wr), .pWrA_i(wrA),
    .pWrCw_i(wrCw), .pWrCw_o(wrCwO), .pRead_i(rd), .pRdA_i(rdA), .pRdValid_i(rdValid),
    .pRdCw_i(rdCw), .pRdCw_o(rdCwO), .pCntClr_i(cntClr), .pSlotArmed_o(armed), .pInjCnt_o(cnt));

  epl_fi_engine #(.ADDR_WIDTH(AW), .CW_WIDTH(CW), .NUM_SLOTS(NS), .RD_LAT(RL), .CNT_WIDTH(2)) dut2 (
    .pCLOCK_i(clk), .nRESET_i(nRst), .pFiEn_i(fiEn), .pCfgWe_i(cfgWe), .pCfgSlot_i(cfgSlot),
    .pCfgAddr_i(cfgAddr), .pCfgMask_i(cfgMask), .pCfgMode_i(cfgMode), .pWrite_i(wr), .pWrA_i(wrA),
    .pWrCw_i(wrCw), .pWrCw_o(wrCwO2), .pRead_i(rd), .pRdA_i(rdA), .pRdValid_i(rdValid),
    .pRdCw_i(rdCw), .pRdCw_o(rdCwO2), .pCntClr_i(cntClr), .pSlotArmed_o(armed2), .pInjCnt_o(cnt2));

  // Behavioural model state
  typedef struct { int t; logic [CW-1:0] m; } tag_t;
  logic [AW-1:0] mAddr [NS];
  logic [CW-1:0] mMask [NS];
  logic [2:0]    mMode [NS];
  tag_t          q[$];
  int            cyc = 0;
  longint        mCnt16 = 0;
  int            mCnt2 = 0;
  bit            modelOk = 1'b0;

  int passed = 0, total = 0;

  // Values seen in the most recent tick, for literal expectations
  logic [CW-1:0] capWr, capRd;
  logic [NS-1:0] capArmed;
  logic [15:0]   capCnt;
  logic [1:0]    capCnt2;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
  endtask

  task automatic tick();
    logic [CW-1:0] z, o, f, r, expWr, expRd, tagM;
    logic [NS-1:0] expArm;
    logic tagV;
    int inc;
    @(negedge clk);
    z = '0; o = '0; f = '0; r = '0;
    for (int s = 0; s < NS; s++) begin
      if (fiEn && wr && mAddr[s] == wrA) begin
        if (mMode[s] == 3'd1) f |= mMask[s];
        if (mMode[s] == 3'd2) z |= mMask[s];
        if (mMode[s] == 3'd3) o |= mMask[s];
      end
      expArm[s] = (mMode[s] >= 3'd1 && mMode[s] <= 3'd5);
    end
    expWr = ((wrCw & ~z) | o) ^ f;
    tagV  = (q.size() > 0 && q[0].t == cyc);
    tagM  = tagV ? q[0].m : '0;
    expRd = (tagV && rdValid) ? (rdCw ^ tagM) : rdCw;
    capWr = wrCwO; capRd = rdCwO; capArmed = armed; capCnt = cnt; capCnt2 = cnt2;
    if (modelOk) begin
      chk("wrCw", 64'(wrCwO), 64'(expWr));
      chk("rdCw", 64'(rdCwO), 64'(expRd));
      chk("armed", 64'(armed), 64'(expArm));
      chk("cnt16", 64'(cnt), 64'(mCnt16));
      chk("cnt2", 64'(cnt2), 64'(mCnt2));
      chk("wrCw_w2", 64'(wrCwO2), 64'(expWr));
      chk("rdCw_w2", 64'(rdCwO2), 64'(expRd));
      chk("armed_w2", 64'(armed2), 64'(expArm));
    end
    // Advance the model across the coming rising edge
    if (!nRst) begin
      for (int s = 0; s < NS; s++) begin mAddr[s] = '0; mMask[s] = '0; mMode[s] = '0; end
      q.delete();
      mCnt16 = 0; mCnt2 = 0;
      modelOk = 1'b1;
    end else begin
      inc = 0;
      if ((z | o | f) != '0) inc++;
      if (tagV && rdValid) inc++;
      if (cntClr) begin mCnt16 = 0; mCnt2 = 0; end
      else begin
        mCnt16 = (mCnt16 + inc > 65535) ? 65535 : mCnt16 + inc;
        mCnt2  = (mCnt2 + inc > 3) ? 3 : mCnt2 + inc;
      end
      if (fiEn && rd) begin
        for (int s = 0; s < NS; s++) begin
          if (mAddr[s] == rdA && (mMode[s] == 3'd4 || mMode[s] == 3'd5)) begin
            r |= mMask[s];
            if (mMode[s] == 3'd5) mMode[s] = 3'd0;
          end
        end
        if (r != '0) q.push_back('{t: cyc + RL, m: r});
      end
      if (cfgWe) begin
        mAddr[cfgSlot] = cfgAddr; mMask[cfgSlot] = cfgMask; mMode[cfgSlot] = cfgMode;
      end
    end
    while (q.size() > 0 && q[0].t <= cyc) void'(q.pop_front());
    cyc++;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; cfgWe = 1'b0; cntClr = 1'b0; rdValid = 1'b0;
  endtask

  task automatic doReset();
    nRst = 1'b0;
    tick();
    tick();
    nRst = 1'b1;
  endtask

  task automatic cfg(input int s, input logic [AW-1:0] a, input logic [CW-1:0] m, input logic [2:0] md);
    cfgWe = 1'b1; cfgSlot = 2'(s); cfgAddr = a; cfgMask = m; cfgMode = md;
    tick();
  endtask

  initial begin
    logic [63:0] rnd;
    #1;
    // Reset state
    doReset();
    tick();
    chk("reset_cnt", 64'(capCnt), 64'd0);
    chk("reset_armed", 64'(capArmed), 64'd0);

    // Stuck-at-0 on write
    cfg(0, 8'h12, 39'h000000000F, 3'b010);
    wr = 1'b1; wrA = 8'h12; wrCw = 39'h7FFFFFFFFF; tick();
    chk("sa0_wr", 64'(capWr), 64'h7FFFFFFFF0);
    tick();
    chk("sa0_cnt", 64'(capCnt), 64'd1);
    wr = 1'b1; wrA = 8'h13; wrCw = 39'h7FFFFFFFFF; tick();
    chk("sa0_miss", 64'(capWr), 64'h7FFFFFFFFF);

    // Combined write modes
    doReset();
    cfg(0, 8'h05, 39'h3, 3'b010);
    cfg(1, 8'h05, 39'h4, 3'b011);
    cfg(2, 8'h05, 39'h1, 3'b001);
    wr = 1'b1; wrA = 8'h05; wrCw = '0; tick();
    chk("combo_wr", 64'(capWr), 64'h5);

    // One-shot read
    doReset();
    cfg(3, 8'h20, 39'h1, 3'b101);
    chk("once_armed", 64'(armed), 64'h8);
    rd = 1'b1; rdA = 8'h20; tick();
    rd = 1'b1; rdA = 8'h20; tick();
    rdValid = 1'b1; rdCw = '0; tick();
    chk("once_rd1", 64'(capRd), 64'h1);
    chk("once_armed0", 64'(capArmed), 64'h0);
    rdValid = 1'b1; rdCw = '0; tick();
    chk("once_rd2", 64'(capRd), 64'h0);
    tick();
    chk("once_cnt", 64'(capCnt), 64'd1);

    // Reconfiguration while a read is in flight
    doReset();
    cfg(0, 8'h40, 39'h2, 3'b100);
    rd = 1'b1; rdA = 8'h40; tick();
    cfgWe = 1'b1; cfgSlot = 2'd0; cfgAddr = 8'h40; cfgMask = 39'h8; cfgMode = 3'b100; tick();
    rdValid = 1'b1; rdCw = '0; tick();
    chk("reconfig_rd", 64'(capRd), 64'h2);

    // Enable gating, then saturation of the 2-bit counter
    cfg(1, 8'h41, 39'h1, 3'b001);
    cntClr = 1'b1; tick();
    fiEn = 1'b0;
    wr = 1'b1; wrA = 8'h41; wrCw = '0; rd = 1'b1; rdA = 8'h40; tick();
    chk("gate_wr", 64'(capWr), 64'h0);
    tick();
    rdValid = 1'b1; rdCw = '0; tick();
    chk("gate_rd", 64'(capRd), 64'h0);
    chk("gate_cnt", 64'(capCnt), 64'd0);
    fiEn = 1'b1;
    for (int i = 0; i < 5; i++) begin wr = 1'b1; wrA = 8'h41; wrCw = '0; tick(); end
    tick();
    chk("sat_cnt2", 64'(capCnt2), 64'd3);
    chk("sat_cnt16", 64'(capCnt), 64'd5);
    cntClr = 1'b1; tick();
    tick();
    chk("clr_cnt2", 64'(capCnt2), 64'd0);

    // Reset while a matching read is in flight
    cfg(2, 8'h40, 39'h4, 3'b100);
    rd = 1'b1; rdA = 8'h40; tick();
    nRst = 1'b0; tick();
    nRst = 1'b1;
    rdValid = 1'b1; rdCw = '0; tick();
    chk("rstmid_rd", 64'(capRd), 64'h0);
    chk("rstmid_armed", 64'(capArmed), 64'h0);
    chk("rstmid_cnt", 64'(capCnt), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      nRst    = ($urandom_range(0, 199) != 0);
      fiEn    = ($urandom_range(0, 9) != 0);
      cfgWe   = ($urandom_range(0, 4) == 0);
      cfgSlot = 2'($urandom_range(0, 3));
      cfgAddr = 8'($urandom_range(0, 3));
      rnd     = {$urandom(), $urandom()};
      cfgMask = ($urandom_range(0, 3) == 0) ? CW'(rnd[3:0]) : rnd[CW-1:0];
      cfgMode = 3'($urandom_range(0, 7));
      wr      = $urandom_range(0, 1) != 0;
      wrA     = 8'($urandom_range(0, 3));
      rnd     = {$urandom(), $urandom()};
      wrCw    = rnd[CW-1:0];
      rd      = $urandom_range(0, 1) != 0;
      rdA     = 8'($urandom_range(0, 3));
      rdValid = ($urandom_range(0, 6) != 0);
      rnd     = {$urandom(), $urandom()};
      rdCw    = rnd[CW-1:0];
      cntClr  = ($urandom_range(0, 39) == 0);
      tick();
    end
    nRst = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/epl_fi_engine.md
# epl_fi_engine

Runtime-programmable fault-injection engine for the ECC-protected FFRAM datapath. It sits between the ECC encoder and the column-access logic on the write path, and between the read mux and the ECC decoder on the read path. It replaces the fixed, compile-time word/bit masks with NUM_SLOTS independently programmable slots. Each slot has its own address match, codeword mask and mode, adding stuck-at-0, stuck-at-1, persistent and one-shot read disturbs, and a saturating injection counter.

## Interface
Parameters:
- ADDR_WIDTH, 8, memory address width
- CW_WIDTH, 39, stored codeword width (data + check bits)
- NUM_SLOTS, 4, number of fault slots (power of 2, ≥2)
- RD_LAT, 2, cycles from pRead_i to codeword valid at pRdCw_i (≥1)
- CNT_WIDTH, 16, injection counter width

Ports:
- pCLOCK_i  in  1  clock, all state on rising edge
- nRESET_i  in  1  synchronous, active-low reset
- pFiEn_i  in  1  global injection enable
- pCfgWe_i  in  1  slot configuration write strobe
- pCfgSlot_i  in  log2(NUM_SLOTS)  slot index for the configuration write
- pCfgAddr_i  in  ADDR_WIDTH  slot match address
- pCfgMask_i  in  CW_WIDTH  slot codeword bit mask
- pCfgMode_i  in  3  slot mode, encoded as:
  - 000 OFF
  - 001 WR_FLIP
  - 010 WR_ZERO
  - 011 WR_ONE
  - 100 RD_FLIP (persistent)
  - 101 RD_ONCE (one-shot)
  - 11x reserved, treated as OFF
- pWrite_i  in  1  write access strobe
- pWrA_i  in  ADDR_WIDTH  write address
- pWrCw_i  in  CW_WIDTH  encoded codeword from the encoder
- pWrCw_o  out  CW_WIDTH  codeword to column access, after injection
- pRead_i  in  1  read issue strobe
- pRdA_i  in  ADDR_WIDTH  read address
- pRdValid_i  in  1  read codeword valid, RD_LAT cycles after pRead_i
- pRdCw_i  in  CW_WIDTH  codeword from the read mux
- pRdCw_o  out  CW_WIDTH  codeword to the decoder, after injection
- pCntClr_i  in  1  clear injection counter
- pSlotArmed_o  out  NUM_SLOTS  bit i = slot i mode is not OFF/reserved
- pInjCnt_o  out  CNT_WIDTH  saturating count of injected accesses

## Operation
- **Slot state.** Each slot holds {addr, mask, mode}. A configuration write loads all three fields of pCfgSlot_i.
- **Write path (combinational, zero latency).** For each slot where the mode is write-type, the address equals pWrA_i, pWrite_i=1 and pFiEn_i=1, OR its mask into the matching class to form Z, O and F:
  - WR_ZERO slots feed Z.
  - WR_ONE slots feed O.
  - WR_FLIP slots feed F.
  - Output: pWrCw_o = ((pWrCw_i & ~Z) | O) ^ F.
  - With no match, pWrCw_o = pWrCw_i.
- **Read issue.** When pRead_i=1 and pFiEn_i=1, compute R as the OR of the masks of RD_FLIP and RD_ONCE slots whose address equals pRdA_i.
  - Push {tag valid = (R≠0), R} into an RD_LAT-deep shift pipeline.
  - Every cycle without pRead_i pushes an empty tag.
  - A matched RD_ONCE slot is consumed at issue: its mode becomes OFF on the next edge. Later reads already in flight are not disturbed by it.
- **Read delivery.** pRdCw_o = pRdCw_i ^ R when the pipeline output tag is valid and pRdValid_i=1; otherwise pRdCw_o = pRdCw_i.
  - A valid tag arriving with pRdValid_i=0 is discarded and not counted.
  - The mask travels with the tag, so reconfiguring a slot does not alter reads already in flight.
- **Counter.** Each cycle, pInjCnt_o increments by the number of injections that cycle: a write with Z|O|F ≠ 0 adds 1, and an applied read tag adds 1. Maximum +2 per cycle; the counter saturates at all-ones.
  - pCntClr_i sets the counter to 0 and takes priority over increments that cycle.
- **pFiEn_i=0.** Nothing is applied or counted at write time or read issue, and no one-shot is consumed. Tags already in the pipeline are still applied.

## Timing
- **Reset** (nRESET_i=0 at a rising edge) clears:
  - all slots to {0, 0, OFF};
  - all pipeline tags to invalid;
  - pInjCnt_o to 0 and pSlotArmed_o to 0.
  
  Consequently pWrCw_o and pRdCw_o pass through unmodified. Reset asserted mid-operation drops every in-flight tag.
- **Configuration latency.** A configuration write takes effect for accesses in the next cycle. A write or read issue in the same cycle as pCfgWe_i sees the old slot contents.
- **Config vs one-shot collision.** If a configuration write hits slot i in the same cycle RD_ONCE slot i is consumed, the configuration write wins.
- **Read alignment.** A tag pushed at cycle t is presented at cycle t+RD_LAT.
- **Concurrency.** Back-to-back reads every cycle are supported. A write and a read delivery may occur in the same cycle.
- **pSlotArmed_o** is registered-state derived and reflects slot modes after each edge.

## Test plan
- **Stuck-at-0 on write.** Slot0 = {0x12, mask 0x000000000F, WR_ZERO}; write 0x12 with cw 0x7FFFFFFFFF → pWrCw_o = 0x7FFFFFFFF0 and cnt = 1. Writing 0x13 passes through.
- **Combined write modes.** Slot0 WR_ZERO mask 0x3, slot1 WR_ONE mask 0x4, slot2 WR_FLIP mask 0x1, all at address 0x05; write cw 0x0 → pWrCw_o = 0x5.
- **One-shot read.** Slot3 = {0x20, 0x1, RD_ONCE}; issue reads of 0x20 at t and t+1 → first delivered codeword has bit0 flipped, second is clean. Expect pSlotArmed_o[3] = 0 after t+1 and cnt = 1.
- **Reconfig in flight.** RD_FLIP slot at 0x40, mask 0x2; read 0x40, then reconfigure the slot to mask 0x8 the next cycle → delivered codeword is XORed with 0x2.
- **Enable gating and saturation.** With pFiEn_i = 0, matching writes and reads pass clean and cnt is unchanged. With CNT_WIDTH forced to 2, 5 injections → cnt = 3; pCntClr_i → 0.
- **Reset mid-read.** Issue a matching read and assert reset on the next cycle → no flip at delivery and all outputs are at reset values.
